seg_scroll_master: RTL and testbench
====================================

SEG_SCROLL_MASTER -- requirements
Module: seg_scroll_master

Interface
REQ-001 SHALL have parameter NUM_SEGMENT, default 6, number of display digits, one Avalon word per digit.
REQ-002 SHALL have parameter MSG_DEPTH, default 16, message buffer depth in nibbles (power of two, at least NUM_SEGMENT).
REQ-003 SHALL have parameter TICK_DIV, default 12_500_000, clock cycles between scroll steps (at least 2).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port enable_i  input  1  scrolling enabled.
REQ-007 SHALL have port msg_len_i  input  $clog2(MSG_DEPTH+1)  active message length, sampled at frame start.
REQ-008 SHALL have ports cfg_we_i  input  1, cfg_addr_i  input  $clog2(MSG_DEPTH), cfg_wdata_i  input  4: message buffer write.
REQ-009 SHALL have ports avm_address_o  output  3, avm_byteenable_o  output  4, avm_write_o  output  1, avm_writedata_o  output  32: Avalon-MM write master to the display peripheral.
REQ-010 SHALL have port avm_waitrequest_i  input  1  slave stall.
REQ-011 SHALL have ports busy_o  output  1  (frame in progress) and frame_done_o  output  1  (one-cycle pulse).

Function
REQ-012 SHALL implement states IDLE, WAIT_TICK, WRITE, NEXT.
REQ-013 IDLE SHALL go to WAIT_TICK when enable_i=1 and clear the tick counter.
REQ-014 WAIT_TICK SHALL count TICK_DIV-1 down to 0 and then go to WRITE. It SHALL latch msg_len_i and set digit index k=0.
REQ-015 In WRITE, avm_write_o SHALL be 1, avm_address_o SHALL be k, avm_byteenable_o SHALL be 4'b0001, and avm_writedata_o SHALL be {28'b0, buf[(offset+k) mod len]}.
REQ-016 Address, data and byteenable SHALL stay stable while avm_waitrequest_i=1. The transfer completes on the cycle with avm_write_o=1 and avm_waitrequest_i=0.
REQ-017 On completion with k<NUM_SEGMENT-1, the FSM SHALL go to NEXT and increment k. NEXT SHALL return to WRITE on the following cycle.
REQ-018 On completion with k=NUM_SEGMENT-1:
- offset SHALL become (offset+1) mod len;
- frame_done_o SHALL pulse on the next cycle;
- the FSM SHALL go to WAIT_TICK if enable_i=1, else IDLE.
REQ-019 The first WRITE cycle SHALL be exactly one cycle after the tick counter reaches 0.
REQ-020 A latched len of 0 SHALL write 4'h0 to every digit and hold offset at 0.
REQ-021 A latched len smaller than NUM_SEGMENT SHALL wrap the index modulo len; a latched len greater than MSG_DEPTH SHALL be clamped to MSG_DEPTH.
REQ-022 Deasserting enable_i during WAIT_TICK SHALL return the FSM to IDLE next cycle. Deasserting enable_i during WRITE or NEXT SHALL complete the frame first.
REQ-023 cfg_we_i SHALL write the buffer in any state. It SHALL be visible to a WRITE read on the next cycle; the buffer is read combinationally at the current index.
REQ-024 busy_o SHALL be 1 in WRITE and NEXT, else 0.
REQ-025 avm_write_o SHALL be 0 in every state except WRITE.

Reset
REQ-026 On rst_n=0 at a clk edge:
- state SHALL be IDLE;
- offset, k and the tick counter SHALL be 0;
- avm_write_o, busy_o and frame_done_o SHALL be 0;
- avm_address_o, avm_byteenable_o and avm_writedata_o SHALL be 0.
REQ-027 The buffer SHALL reset to all 4'h0.
REQ-028 Reset mid-transfer SHALL drop avm_write_o on the next cycle without waiting for waitrequest.

Structure
REQ-029 The state enum and byteenable constant 4'b0001 SHALL live in shared package seg_ctrl_pkg.
REQ-030 The tick prescaler SHALL be sub-module seg_tick_gen, with inputs clk, rst_n and clear, and output tick.
REQ-031 The implementation SHALL be 120-400 RTL lines with no inferred latches.

Verification
REQ-032 Scenario, basic frame. Stimulus: TICK_DIV=4, len=6, buf=0..5, enable=1. Response: writes addr0..5 with data 0..5, then frame_done, then the next frame writes 1,2,3,4,5,0.
REQ-033 Scenario, waitrequest. Stimulus: waitrequest=1 for 3 cycles on addr2. Response: addr/data held at 2/2 for 4 cycles, then addr3 follows.
REQ-034 Scenario, short message. Stimulus: len=3, buf=A,B,C. Response: frame writes A,B,C,A,B,C; next frame B,C,A,B,C,A.
REQ-035 Scenario, zero length. Stimulus: len=0. Response: six writes of 0, offset stays 0.
REQ-036 Scenario, enable drop. Stimulus: enable=0 at addr1 in WRITE. Response: addr2..5 still written, frame_done pulses, then IDLE with no further writes.
REQ-037 Scenario, mid-transfer reset. Stimulus: rst_n=0 during WRITE with waitrequest=1. Response: avm_write_o=0 next cycle, all outputs 0, state IDLE.

Source files
------------

// File: rtl/seg_ctrl_pkg.sv
// Shared definitions for the scrolling seven-segment master: FSM encoding,
// the fixed byte lane used for digit writes and a data-word helper.
package seg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    WRITE     = 2'd2,
    NEXT      = 2'd3
  } seg_state_e;

  // Digit nibbles always travel in the lowest byte lane of the word.
  localparam logic [3:0] SEG_BYTEENABLE = 4'b0001;

  function automatic logic [31:0] seg_data_word(input logic [3:0] nibble);
    return {28'b0, nibble};
  endfunction

endpackage

// File: rtl/seg_scroll_master_if.sv
// Avalon-MM write-only link between the scroll master and the display
// peripheral.
interface seg_scroll_master_if;

  logic [2:0]  address;
  logic [3:0]  byteenable;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;

  modport master (
    output address,
    output byteenable,
    output write,
    output writedata,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  byteenable,
    input  write,
    input  writedata,
    output waitrequest
  );

endinterface

// File: rtl/seg_tick_gen.sv
// Scroll-step prescaler: counts TICK_DIV-1 down to 0 and flags the zero
// cycle. Holding clear restarts the interval from the top.
module seg_tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Down-counter, reloaded on clear and after each zero so the interval repeats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = !clear && (cnt_q == '0);

endmodule

// File: rtl/seg_scroll_master.sv
// Scrolling message master: every tick it writes NUM_SEGMENT digits of the
// message buffer to the display over Avalon-MM, starting one nibble further
// along the message each frame.
module seg_scroll_master
  import seg_ctrl_pkg::*;
#(
  parameter int NUM_SEGMENT = 6,
  parameter int MSG_DEPTH   = 16,
  parameter int TICK_DIV    = 12_500_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable_i,
  input  logic [$clog2(MSG_DEPTH+1)-1:0] msg_len_i,
  input  logic                           cfg_we_i,
  input  logic [$clog2(MSG_DEPTH)-1:0]   cfg_addr_i,
  input  logic [3:0]                     cfg_wdata_i,
  seg_scroll_master_if.master            avm,
  output logic                           busy_o,
  output logic                           frame_done_o
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int SW = LW + 3;
  localparam logic [2:0]    LAST_K    = 3'(NUM_SEGMENT - 1);
  localparam logic [LW-1:0] DEPTH_LEN = LW'(MSG_DEPTH);

  seg_state_e    state_q;
  logic [AW-1:0] offset_q;
  logic [2:0]    k_q;
  logic [LW-1:0] len_q;
  logic [3:0]    msg_buf [MSG_DEPTH];

  logic          tick;
  logic          tick_clear;
  logic [LW-1:0] len_clamped;
  logic [SW-1:0] sum_w;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] offset_nxt;
  logic [3:0]    data_nib;

  // The interval only runs while waiting; every other state holds it at the top.
  assign tick_clear = (state_q != WAIT_TICK);

  seg_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign len_clamped = (msg_len_i > DEPTH_LEN) ? DEPTH_LEN : msg_len_i;

  // Message buffer: cleared on reset, writable at any time through the cfg port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg_buf[i] <= 4'h0;
      end
    end else if (cfg_we_i) begin
      msg_buf[cfg_addr_i] <= cfg_wdata_i;
    end
  end

  // Circular read position and next-frame start, both modulo the latched length.
  always_comb begin
    sum_w      = SW'(offset_q) + SW'(k_q);
    rd_idx     = '0;
    offset_nxt = '0;
    if (len_q != '0) begin
      rd_idx     = AW'(sum_w % SW'(len_q));
      offset_nxt = AW'((SW'(offset_q) + SW'(1)) % SW'(len_q));
    end
  end

  assign data_nib = (len_q == '0) ? 4'h0 : msg_buf[rd_idx];

  // Frame sequencer: wait for the tick, then write each digit in turn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      offset_q     <= '0;
      k_q          <= '0;
      len_q        <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q <= WAIT_TICK;
          end
        end
        WAIT_TICK: begin
          if (!enable_i) begin
            state_q <= IDLE;
          end else if (tick) begin
            state_q <= WRITE;
            len_q   <= len_clamped;
            k_q     <= '0;
          end
        end
        WRITE: begin
          if (!avm.waitrequest) begin
            if (k_q == LAST_K) begin
              offset_q     <= offset_nxt;
              frame_done_o <= 1'b1;
              state_q      <= enable_i ? WAIT_TICK : IDLE;
            end else begin
              k_q     <= k_q + 3'd1;
              state_q <= NEXT;
            end
          end
        end
        NEXT: begin
          state_q <= WRITE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Bus outputs are driven only in WRITE and are zero otherwise.
  always_comb begin
    avm.write      = 1'b0;
    avm.address    = '0;
    avm.byteenable = '0;
    avm.writedata  = '0;
    if (state_q == WRITE) begin
      avm.write      = 1'b1;
      avm.address    = k_q;
      avm.byteenable = SEG_BYTEENABLE;
      avm.writedata  = seg_data_word(data_nib);
    end
  end

  assign busy_o = (state_q == WRITE) || (state_q == NEXT);

endmodule

// File: tb/tb_seg_scroll_master.sv
// Directed and randomized bench for seg_scroll_master with a frame-level
// reference model of the scrolling message.
module tb_seg_scroll_master;

  localparam int NSEG  = 6;
  localparam int DEPTH = 16;
  localparam int TDIV  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [4:0] msg_len = '0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [3:0] cfg_wdata = '0;
  logic       busy;
  logic       frame_done;

  seg_scroll_master_if avm ();

  seg_scroll_master #(
    .NUM_SEGMENT (NSEG),
    .MSG_DEPTH   (DEPTH),
    .TICK_DIV    (TDIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable),
    .msg_len_i    (msg_len),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .avm          (avm),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         failures = 0;
  logic [3:0] mbuf [DEPTH];
  int         modelOffset = 0;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cfg write into the message buffer, mirrored into the model.
  task automatic applyStimulus(input int addr, input logic [3:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = 4'(addr);
    cfg_wdata = data;
    stepCycle();
    cfg_we    = 1'b0;
    mbuf[addr] = data;
  endtask

  task automatic checkIdle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      stepCycle();
      checkOutput(tag, {30'b0, avm.write, busy}, 32'd0);
    end
  endtask

  function automatic logic [31:0] expDigit(input int k, input int len);
    if (len == 0) return 32'd0;
    return {28'b0, mbuf[(modelOffset + k) % len]};
  endfunction

  // Waits for a frame, then checks every digit write against the model.
  task automatic runFrame(input int gap, input int stallDigit, input int stallLen,
                          input bit randStall, input int dropAt);
    int n;
    int len;
    int s;
    logic [31:0] expWord;
    len = (int'(msg_len) > DEPTH) ? DEPTH : int'(msg_len);
    n = 0;
    while (!avm.write && n < 4 * TDIV + 20) begin
      stepCycle();
      n++;
      checkOutput("done_pulse", {31'b0, frame_done}, 32'd0);
    end
    checkOutput("frame_start", {31'b0, avm.write}, 32'd1);
    if (!avm.write) return;
    if (gap > 0) checkOutput("tick_gap", n, gap);
    for (int k = 0; k < NSEG; k++) begin
      s = (k == stallDigit) ? stallLen : (randStall ? int'($urandom_range(0, 2)) : 0);
      expWord = expDigit(k, len);
      for (int c = 0; c <= s; c++) begin
        avm.waitrequest = (c < s);
        if (k == dropAt && c == 0) enable = 1'b0;
        checkOutput("wr_write", {31'b0, avm.write}, 32'd1);
        checkOutput("wr_addr", {29'b0, avm.address}, k);
        checkOutput("wr_data", avm.writedata, expWord);
        checkOutput("wr_be", {28'b0, avm.byteenable}, 32'h1);
        checkOutput("wr_busy", {31'b0, busy}, 32'd1);
        checkOutput("wr_done", {31'b0, frame_done}, 32'd0);
        stepCycle();
      end
      if (k < NSEG - 1) begin
        checkOutput("next_write", {31'b0, avm.write}, 32'd0);
        checkOutput("next_busy", {31'b0, busy}, 32'd1);
        stepCycle();
      end else begin
        checkOutput("end_done", {31'b0, frame_done}, 32'd1);
        checkOutput("end_busy", {31'b0, busy}, 32'd0);
        checkOutput("end_write", {31'b0, avm.write}, 32'd0);
      end
    end
    modelOffset = (len == 0) ? 0 : (modelOffset + 1) % len;
  endtask

  initial begin
    int n;
    avm.waitrequest = 1'b0;
    for (int i = 0; i < DEPTH; i++) mbuf[i] = 4'h0;

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst_write", {31'b0, avm.write}, 32'd0);
    checkOutput("rst_addr", {29'b0, avm.address}, 32'd0);
    checkOutput("rst_be", {28'b0, avm.byteenable}, 32'd0);
    checkOutput("rst_data", avm.writedata, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, frame_done}, 32'd0);
    rst_n = 1'b1;

    // Basic frame with a stalled digit 2, then the scrolled frame
    for (int i = 0; i < NSEG; i++) applyStimulus(i, 4'(i));
    msg_len = 5'd6;
    enable = 1'b1;
    runFrame(TDIV + 1, 2, 3, 1'b0, -1);
    runFrame(TDIV, -1, 0, 1'b0, -1);

    // Reset while a write is stalled
    n = 0;
    while (!avm.write && n < 4 * TDIV + 20) begin
      stepCycle();
      n++;
    end
    checkOutput("mid_start", {31'b0, avm.write}, 32'd1);
    avm.waitrequest = 1'b1;
    stepCycle();
    checkOutput("mid_hold", {31'b0, avm.write}, 32'd1);
    rst_n = 1'b0;
    enable = 1'b0;
    stepCycle();
    checkOutput("mid_write", {31'b0, avm.write}, 32'd0);
    checkOutput("mid_addr", {29'b0, avm.address}, 32'd0);
    checkOutput("mid_be", {28'b0, avm.byteenable}, 32'd0);
    checkOutput("mid_data", avm.writedata, 32'd0);
    checkOutput("mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("mid_done", {31'b0, frame_done}, 32'd0);
    stepCycle();
    rst_n = 1'b1;
    avm.waitrequest = 1'b0;
    for (int i = 0; i < DEPTH; i++) mbuf[i] = 4'h0;
    modelOffset = 0;
    checkIdle(2 * TDIV, "idle_after_rst");

    // Cleared buffer, enable dropped at digit 1
    msg_len = 5'd6;
    enable = 1'b1;
    runFrame(TDIV + 1, -1, 0, 1'b0, 1);
    checkIdle(3 * TDIV, "idle_after_drop");

    // Zero length, then a three-nibble message
    applyStimulus(0, 4'hA);
    applyStimulus(1, 4'hB);
    applyStimulus(2, 4'hC);
    for (int i = 3; i < DEPTH; i++) applyStimulus(i, 4'($urandom_range(1, 15)));
    msg_len = 5'd0;
    enable = 1'b1;
    runFrame(TDIV + 1, -1, 0, 1'b1, -1);
    runFrame(TDIV, -1, 0, 1'b0, -1);
    msg_len = 5'd3;
    runFrame(TDIV, -1, 0, 1'b0, -1);
    runFrame(TDIV, -1, 0, 1'b1, -1);

    // Random lengths (including clamped ones), stalls and buffer updates
    for (int f = 0; f < 8; f++) begin
      msg_len = 5'($urandom_range(0, 31));
      applyStimulus(int'($urandom_range(0, DEPTH - 1)), 4'($urandom));
      runFrame(0, -1, 0, 1'b1, -1);
    end

    // Enable dropped while waiting for the tick
    enable = 1'b0;
    checkIdle(3 * TDIV, "idle_wait_drop");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
